// File: rtl/mem_access.sv
// MEM-stage access unit: routes loads/stores to the external data SRAM (req/ack) or to memory-mapped UART registers.
// Optional SRAM ack timeout with sticky error flag: define MEM_TIMEOUT_EN.
module mem_access #(
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01
`ifdef MEM_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 15
`endif
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [15:0] addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] memres_o,
  output logic        stall_o,
  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [15:0] ram_addr_o,
  output logic [15:0] ram_wdata_o,
  input  logic [15:0] ram_rdata_i,
  input  logic        ram_ack_i,
  input  logic        uart_rx_ready_i,
  input  logic        uart_tx_ready_i,
  input  logic [7:0]  uart_rdata_i,
  output logic        uart_rd_o,
  output logic        uart_wr_o,
  output logic [7:0]  uart_wdata_o,
  output logic        err_o
);

  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] memres_q, memres_d;
  logic          req_d, we_d;
  logic [DW-1:0] addr_d, wdata_d;
  logic          req, is_uart_data, is_uart_stat;

  // Reset masks the request so no strobe or stall leaks out while RST is held
  assign req          = (memread_i | memwrite_i) & ~RST;
  assign is_uart_data = (addr_i == UART_DATA_ADDR);
  assign is_uart_stat = (addr_i == UART_STAT_ADDR);
  assign uart_wdata_o = wdata_i[BW-1:0];

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = 8;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          expired;

  assign expired = (cnt_q == CW'(TIMEOUT - 1));
  assign err_o   = err_q;
`else
  assign err_o   = 1'b0;
`endif

  // Next-state, register loads and combinational outputs
  always_comb begin
    state_d   = state_q;
    memres_d  = memres_q;
    req_d     = ram_req_o;
    we_d      = ram_we_o;
    addr_d    = ram_addr_o;
    wdata_d   = ram_wdata_o;
    memres_o  = '0;
    stall_o   = 1'b0;
    uart_rd_o = 1'b0;
    uart_wr_o = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d     = cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req && !is_uart_data && !is_uart_stat) begin
          stall_o = 1'b1;
          state_d = S_WAIT;
          req_d   = 1'b1;
          we_d    = memwrite_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (req && is_uart_data) begin
          if (memwrite_i) begin
            uart_wr_o = 1'b1;
          end else begin
            uart_rd_o = 1'b1;
            memres_o  = {8'h00, uart_rdata_i};
          end
        end else if (req && is_uart_stat && !memwrite_i) begin
          memres_o = {14'b0, uart_rx_ready_i, uart_tx_ready_i};
        end
      end
      S_WAIT: begin
        stall_o  = 1'b1;
        memres_o = memres_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d    = cnt_q + CW'(1);
`endif
        // An ack in the expiry cycle takes priority over the timeout
        if (ram_ack_i) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          if (!ram_we_o) memres_d = ram_rdata_i;
`ifdef MEM_TIMEOUT_EN
        end else if (expired) begin
          state_d = S_DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          if (!ram_we_o) memres_d = '1;
`endif
        end
      end
      S_DONE: begin
        memres_o = memres_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and SRAM-side registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      memres_q    <= '0;
      ram_req_o   <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
    end else begin
      state_q     <= state_d;
      memres_q    <= memres_d;
      ram_req_o   <= req_d;
      ram_we_o    <= we_d;
      ram_addr_o  <= addr_d;
      ram_wdata_o <= wdata_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Wait counter and sticky timeout flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: UART/idle vector table, directed SRAM and reset corner cases, randomized traffic vs a reference model.
// Build with MEM_TIMEOUT_EN defined to also exercise the timeout path (TIMEOUT = 4).
module tb_mem_access;

  logic        CLK, RST;
  logic        memread_i, memwrite_i;
  logic [15:0] addr_i, wdata_i, memres_o;
  logic        stall_o, ram_req_o, ram_we_o;
  logic [15:0] ram_addr_o, ram_wdata_o, ram_rdata_i;
  logic        ram_ack_i, uart_rx_ready_i, uart_tx_ready_i;
  logic [7:0]  uart_rdata_i, uart_wdata_o;
  logic        uart_rd_o, uart_wr_o, err_o;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO  = 4;
  localparam int MAXN = 3;
  mem_access #(.TIMEOUT(TMO)) dut (
`else
  localparam int MAXN = 6;
  mem_access dut (
`endif
    .CLK(CLK), .RST(RST), .memread_i(memread_i), .memwrite_i(memwrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .memres_o(memres_o), .stall_o(stall_o),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_ack_i(ram_ack_i),
    .uart_rx_ready_i(uart_rx_ready_i), .uart_tx_ready_i(uart_tx_ready_i),
    .uart_rdata_i(uart_rdata_i), .uart_rd_o(uart_rd_o), .uart_wr_o(uart_wr_o),
    .uart_wdata_o(uart_wdata_o), .err_o(err_o)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] m_res;  // expected content of the load-result register

  typedef struct {
    logic        rd, wr;
    logic [15:0] addr, wdata;
    logic        rx, tx;
    logic [7:0]  urd;
    logic [15:0] exp_res;
    logic        exp_stall, exp_rd, exp_wr;
    logic [7:0]  exp_wd;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rules for a single-cycle access made while the unit is idle
  function automatic vec_t comb_model(input vec_t v);
    vec_t r = v;
    logic req = v.rd | v.wr;
    r.exp_res = 16'h0; r.exp_stall = 1'b0; r.exp_rd = 1'b0; r.exp_wr = 1'b0;
    r.exp_wd = v.wdata[7:0];
    if (req && v.addr == 16'hBF00) begin
      if (v.wr) r.exp_wr = 1'b1;
      else begin r.exp_rd = 1'b1; r.exp_res = {8'h00, v.urd}; end
    end else if (req && v.addr == 16'hBF01) begin
      if (!v.wr) r.exp_res = {14'b0, v.rx, v.tx};
    end
    return r;
  endfunction

  task automatic apply_vec(input vec_t v, input string tag);
    memread_i = v.rd; memwrite_i = v.wr; addr_i = v.addr; wdata_i = v.wdata;
    uart_rx_ready_i = v.rx; uart_tx_ready_i = v.tx; uart_rdata_i = v.urd;
    @(negedge CLK);
    check({tag, "_memres"}, memres_o, v.exp_res);
    check({tag, "_stall"}, stall_o, v.exp_stall);
    check({tag, "_uart_rd"}, uart_rd_o, v.exp_rd);
    check({tag, "_uart_wr"}, uart_wr_o, v.exp_wr);
    check({tag, "_uart_wdata"}, uart_wdata_o, v.exp_wd);
    @(posedge CLK); #1;
    memread_i = 1'b0; memwrite_i = 1'b0;
  endtask

  // One SRAM access; ack arrives in WAIT cycle n (n = 0: never acked)
  task automatic sram_op(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd,
                         input int n, input logic [15:0] rdat, input int exp_stalls, input logic [15:0] exp_res);
    int stalls = 0;
    int waits = 0;
    bit done = 1'b0;
    memread_i = rd; memwrite_i = wr; addr_i = a; wdata_i = wd;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge CLK);
      if (stall_o) begin
        stalls++;
        if (ram_req_o) begin
          waits++;
          if (waits == 1) begin
            check("sram_we", ram_we_o, wr);
            check("sram_addr", ram_addr_o, a);
            if (wr) check("sram_wdata", ram_wdata_o, wd);
          end
          if (waits == n) begin ram_ack_i = 1'b1; ram_rdata_i = rdat; end
        end
      end else if (stalls > 0) begin
        check("done_memres", memres_o, exp_res);
        check("done_req_low", ram_req_o, 1'b0);
        done = 1'b1;
      end
      @(posedge CLK); #1;
      ram_ack_i = 1'b0; ram_rdata_i = 16'($urandom);
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL sram_done: access never completed, stall cycles %0d", stalls);
    end
    check("stall_cycles", stalls, exp_stalls);
    memread_i = 1'b0; memwrite_i = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vec_t v;
    logic wr, rd;
    logic [15:0] a, wd, rdat;
    int n;

    vecs[0] = '{1'b1, 1'b0, 16'hBF01, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0002, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 16'hBF00, 16'h0000, 1'b0, 1'b0, 8'h41, 16'h0041, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 16'hBF00, 16'h1255, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h55};
    vecs[3] = '{1'b0, 1'b0, 16'hBF00, 16'h0000, 1'b1, 1'b1, 8'h77, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{1'b0, 1'b1, 16'hBF01, 16'h00AA, 1'b1, 1'b1, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 8'hAA};
    vecs[5] = '{1'b1, 1'b0, 16'hBF01, 16'h0000, 1'b0, 1'b1, 8'h00, 16'h0001, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[6] = '{1'b1, 1'b1, 16'hBF00, 16'h3C96, 1'b1, 1'b1, 8'hE5, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h96};
    vecs[7] = '{1'b1, 1'b0, 16'hBF01, 16'h0000, 1'b1, 1'b1, 8'h00, 16'h0003, 1'b0, 1'b0, 1'b0, 8'h00};

    RST = 1'b1; memread_i = 1'b1; memwrite_i = 1'b0; addr_i = 16'h4000; wdata_i = 16'h0;
    ram_rdata_i = 16'h0; ram_ack_i = 1'b0; uart_rx_ready_i = 1'b0; uart_tx_ready_i = 1'b0;
    uart_rdata_i = 8'h0; m_res = 16'h0;

    // Reset held with a pending SRAM load
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_memres", memres_o, 16'h0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_req", ram_req_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_uart_rd", uart_rd_o, 1'b0);
    @(posedge CLK); #1;
    RST = 1'b0; memread_i = 1'b0;

    for (int i = 0; i < 8; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Directed SRAM load and store
    m_res = 16'h1234;
    sram_op(1'b1, 1'b0, 16'h4000, 16'h0, 3, 16'h1234, 4, m_res);
    sram_op(1'b0, 1'b1, 16'h8000, 16'hBEEF, 1, 16'h5555, 2, m_res);
    @(negedge CLK);
    check("post_store_idle_stall", stall_o, 1'b0);
    check("post_store_idle_memres", memres_o, 16'h0);
    @(posedge CLK); #1;

    // Reset in the second WAIT cycle, late ack afterwards
    memread_i = 1'b1; addr_i = 16'h2468;
    repeat (2) @(posedge CLK);
    #1;
    check("mid_wait_req_before", ram_req_o, 1'b1);
    RST = 1'b1; memread_i = 1'b0;
    @(posedge CLK); #1;
    check("mid_wait_req_dropped", ram_req_o, 1'b0);
    RST = 1'b0; ram_ack_i = 1'b1; ram_rdata_i = 16'hDEAD;
    @(negedge CLK);
    check("late_ack_stall", stall_o, 1'b0);
    @(posedge CLK); #1;
    ram_ack_i = 1'b0;
    @(negedge CLK);
    check("late_ack_no_done_memres", memres_o, 16'h0);
    check("late_ack_req", ram_req_o, 1'b0);
    @(posedge CLK); #1;
    m_res = 16'h0;
    // Register was cleared: a store's DONE cycle must show zero
    sram_op(1'b0, 1'b1, 16'h0010, 16'hCAFE, 2, 16'h1111, 3, m_res);

`ifdef MEM_TIMEOUT_EN
    m_res = 16'hA5A5;
    sram_op(1'b1, 1'b0, 16'h3000, 16'h0, TMO, 16'hA5A5, TMO + 1, m_res);
    check("ack_at_expiry_err", err_o, 1'b0);
    m_res = 16'hFFFF;
    sram_op(1'b1, 1'b0, 16'h3002, 16'h0, 0, 16'h0, TMO + 1, m_res);
    check("timeout_err", err_o, 1'b1);
    m_res = 16'h0F0F;
    sram_op(1'b1, 1'b0, 16'h3004, 16'h0, 1, 16'h0F0F, 2, m_res);
    check("timeout_err_sticky", err_o, 1'b1);
    sram_op(1'b0, 1'b1, 16'h3006, 16'h7777, 0, 16'h0, TMO + 1, m_res);
    check("timeout_write_err", err_o, 1'b1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; m_res = 16'h0;
    check("err_cleared_by_rst", err_o, 1'b0);
`endif

    // Randomized traffic against the reference rules
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: begin
          wr = 1'($urandom_range(0, 1));
          rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
          a = 16'($urandom) & 16'h7FFF;
          wd = 16'($urandom);
          rdat = 16'($urandom);
          n = $urandom_range(1, MAXN);
          if (!wr) m_res = rdat;
          sram_op(rd, wr, a, wd, n, rdat, n + 1, m_res);
        end
        1: begin
          v.rd = 1'($urandom_range(0, 1)); v.wr = 1'($urandom_range(0, 1));
          v.addr = $urandom_range(0, 1) ? 16'hBF01 : 16'hBF00;
          v.wdata = 16'($urandom); v.rx = 1'($urandom_range(0, 1)); v.tx = 1'($urandom_range(0, 1));
          v.urd = 8'($urandom);
          apply_vec(comb_model(v), "rnd_uart");
        end
        default: begin
          v.rd = 1'b0; v.wr = 1'b0; v.addr = 16'($urandom); v.wdata = 16'($urandom);
          v.rx = 1'($urandom_range(0, 1)); v.tx = 1'($urandom_range(0, 1)); v.urd = 8'($urandom);
          apply_vec(comb_model(v), "rnd_idle");
        end
      endcase
    end
    check("final_err", err_o, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MEM-stage memory access unit of the 16-bit pipeline, between the EX/MEM register and the MEM/WB register.
- Decodes the load/store address and routes it to one of two targets:
  - external data SRAM, through a req/ack handshake;
  - memory-mapped UART registers at 0xBF00 and 0xBF01.
- Drives memres_o into MEM/WB. Asserts stall_o to freeze the pipeline while an SRAM access is outstanding.

Parameters:
- UART_DATA_ADDR, 16'hBF00, UART data register address.
- UART_STAT_ADDR, 16'hBF01, UART status register address.
- TIMEOUT, 15, maximum cycles waiting for ram_ack_i. Used only when MEM_TIMEOUT_EN is defined. Legal range 1..255.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous reset, active-high.
- memread_i  in  1  load request from EX/MEM.
- memwrite_i  in  1  store request from EX/MEM.
- addr_i  in  16  effective address (ALU result).
- wdata_i  in  16  store data.
- memres_o  out  16  load result, sampled by MEM/WB.
- stall_o  out  1  freeze PC/IF/ID/EX/MEM and hold EX/MEM while high.
- ram_req_o  out  1  SRAM request, held until ack.
- ram_we_o  out  1  1 = write, 0 = read; valid while ram_req_o is high.
- ram_addr_o  out  16  SRAM address.
- ram_wdata_o  out  16  SRAM write data.
- ram_rdata_i  in  16  SRAM read data; valid in the ack cycle.
- ram_ack_i  in  1  one-cycle SRAM completion pulse.
- uart_rx_ready_i  in  1  receive byte available.
- uart_tx_ready_i  in  1  transmitter idle.
- uart_rdata_i  in  8  received byte.
- uart_rd_o  out  1  one-cycle pop strobe.
- uart_wr_o  out  1  one-cycle transmit strobe.
- uart_wdata_o  out  8  transmit byte, equal to wdata_i[7:0].
- err_o  out  1  sticky SRAM timeout flag.

Behaviour:
- Request classification:
  - req = memread_i | memwrite_i.
  - If both are high, the access is treated as a write.
  - Any address other than UART_DATA_ADDR or UART_STAT_ADDR is an SRAM access.
- Reset (RST high at posedge):
  - state = IDLE, memres register = 0, ram_req_o = 0, err_o = 0.
  - stall_o = 0, uart_rd_o = 0, uart_wr_o = 0.
  - Reset during WAIT drops ram_req_o at that same edge. A late ack arriving in IDLE is ignored.
- FSM states: IDLE, WAIT, DONE.
  - IDLE to WAIT: req with an SRAM address. Registers ram_req_o = 1, ram_we_o, ram_addr_o, ram_wdata_o. stall_o is high combinationally in this IDLE cycle.
  - WAIT: ram_req_o and the address/data registers stay stable; stall_o = 1.
  - WAIT to DONE: on ram_ack_i. Drop ram_req_o. For a read, capture ram_rdata_i into the memres register; for a write, the register is left unchanged.
  - DONE: stall_o = 0 and memres_o = registered value, so MEM/WB latches at the next edge. DONE to IDLE unconditionally.
  - SRAM access latency: N+2 cycles, where N = cycles from request to ack (minimum 1).
- UART accesses (IDLE only) never stall; the result is combinational in the same cycle:
  - Read of UART_DATA_ADDR: memres_o = {8'h00, uart_rdata_i}, uart_rd_o = 1 for that cycle. rx_ready is not checked; software polls status.
  - Write to UART_DATA_ADDR: uart_wr_o = 1, uart_wdata_o = wdata_i[7:0].
  - Read of UART_STAT_ADDR: memres_o = {14'b0, uart_rx_ready_i, uart_tx_ready_i}.
  - Write to UART_STAT_ADDR: ignored; no strobe, no stall.
- No req in IDLE: memres_o = 0, stall_o = 0, no strobes.
- EX/MEM contents stay constant while stall_o is high. A new SRAM request is accepted only from IDLE, so the earliest back-to-back SRAM access starts the cycle after DONE.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If count reaches TIMEOUT with no ack: go to DONE, drop ram_req_o, load memres register with 16'hFFFF (reads), set err_o = 1.
  - err_o stays set until RST.
  - An ack arriving in the same cycle as expiry wins: normal completion, err_o unchanged.
- Not defined:
  - WAIT has no bound; no counter logic.
  - err_o is tied to 0.

Test Plan:
- Reset: assert RST with memread_i = 1 on an SRAM address -> memres_o = 0, stall_o = 0, ram_req_o = 0, err_o = 0 while reset is held.
- SRAM load: addr 16'h4000, ack after 3 cycles with rdata 16'h1234 -> stall_o high for 4 cycles, ram_we_o = 0, memres_o = 16'h1234 in the DONE cycle, then IDLE.
- SRAM store: addr 16'h8000, wdata 16'hBEEF, ack after 1 cycle -> ram_we_o = 1, ram_wdata_o = 16'hBEEF, stall_o high for 2 cycles.
- UART: read 0xBF01 with rx = 1, tx = 0 -> memres_o = 16'h0002, no stall. Read 0xBF00 with rdata 8'h41 -> memres_o = 16'h0041 and a single uart_rd_o pulse. Write 0xBF00 with wdata 16'h1255 -> uart_wr_o pulse, uart_wdata_o = 8'h55.
- Reset mid-WAIT: RST asserted in the second WAIT cycle -> ram_req_o = 0 at that edge. An ack one cycle later produces no DONE.
- MEM_TIMEOUT_EN defined, TIMEOUT = 4, no ack -> DONE after 4 WAIT cycles, memres_o = 16'hFFFF, err_o = 1 held until RST.
